// File: rtl/counter8_sched_pkg.sv
// Shared types and helpers for the counter8 round-robin scheduler.
// Optional abort support is enabled by defining COUNTER8_SCHED_ABORT_EN.
package counter8_sched_pkg;

    localparam int CNT_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COUNT,
        DONE
    } sched_state_e;

    // A single requester still needs a 1-bit index.
    function automatic int idx_w(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/counter8_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after the pointer, wrapping.
module rr_arbiter
    import counter8_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   pointer,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   index
);

    logic             found;
    logic [IDX_W-1:0] k;

    always_comb begin
        // NOTE: every output gets a default first so no path through the loop infers a latch.
        grant = '0;
        index = '0;
        found = 1'b0;
        k     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = IDX_W'((int'(pointer) + i) % NUM_REQ);
            if (!found && req[k]) begin
                found    = 1'b1;
                grant[k] = 1'b1;
                index    = k;
            end
        end
    end

endmodule

// File: rtl/counter8_sched.sv
// Round-robin scheduler owning the control pins of one shared counter8.
// Define COUNTER8_SCHED_ABORT_EN to add abort_i / aborted_o.
module counter8_sched
    import counter8_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = CNT_W_DEFAULT
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_REQ-1:0]       req_i,
    input  logic [NUM_REQ*CNT_W-1:0] delay_i,
    output logic [NUM_REQ-1:0]       gnt_o,
    output logic [NUM_REQ-1:0]       done_o,
    output logic                     busy_o,
    output logic                     load_o,
    output logic                     en_o,
    output logic [CNT_W-1:0]         data_o,
    input  logic [CNT_W-1:0]         cnt_i
`ifdef COUNTER8_SCHED_ABORT_EN
    ,
    input  logic                     abort_i,
    output logic                     aborted_o
`endif
);

    localparam int IDX_W = idx_w(NUM_REQ);

    sched_state_e      state;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  idx_q;
    logic [CNT_W-1:0]  delay_q;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic [CNT_W-1:0]   delay_arr [NUM_REQ];
    logic               abort_hit;
    logic               at_target;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign delay_arr[g] = delay_i[g*CNT_W +: CNT_W];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req     (req_i),
        .pointer (rr_ptr),
        .grant   (arb_gnt),
        .index   (arb_idx)
    );

`ifdef COUNTER8_SCHED_ABORT_EN
    assign abort_hit = abort_i && ((state == LOAD) || (state == COUNT));
`else
    assign abort_hit = 1'b0;
`endif

    assign at_target = (cnt_i == delay_q);

    // Counter pins are gated by rst_i so they drop in the reset cycle itself.
    assign load_o = !rst_i && (state == LOAD);
    assign en_o   = !rst_i && (state == COUNT) && !at_target && !abort_hit;
    assign data_o = '0;
    assign busy_o = (state != IDLE);

    // NOTE: reset is synchronous, so it lives inside the clocked block rather than the sensitivity list.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            gnt_o   <= '0;
            done_o  <= '0;
            rr_ptr  <= '0;
            idx_q   <= '0;
            delay_q <= '0;
`ifdef COUNTER8_SCHED_ABORT_EN
            aborted_o <= 1'b0;
`endif
        end else begin
            // NOTE: state updates use non-blocking assignments so every register sees pre-edge values.
            case (state)
                IDLE: begin
                    if (|req_i) begin
                        idx_q   <= arb_idx;
                        delay_q <= delay_arr[arb_idx];
                        gnt_o   <= arb_gnt;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    if (abort_hit) begin
                        done_o <= gnt_o;
                        gnt_o  <= '0;
                        state  <= DONE;
`ifdef COUNTER8_SCHED_ABORT_EN
                        aborted_o <= 1'b1;
`endif
                    end else begin
                        state <= COUNT;
                    end
                end
                COUNT: begin
                    if (abort_hit || at_target) begin
                        done_o <= gnt_o;
                        gnt_o  <= '0;
                        state  <= DONE;
`ifdef COUNTER8_SCHED_ABORT_EN
                        aborted_o <= abort_hit;
`endif
                    end
                end
                DONE: begin
                    done_o <= '0;
                    rr_ptr <= (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
                    state  <= IDLE;
`ifdef COUNTER8_SCHED_ABORT_EN
                    aborted_o <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_counter8_sched.sv
// Scoreboard bench for counter8_sched with a behavioural counter8 and a job-level schedule model.
module tb_counter8_sched;

    localparam int N = 4;
    localparam int W = 8;

    logic             clk = 1'b0;
    logic             rst_i;
    logic [N-1:0]     req_i;
    logic [N*W-1:0]   delay_i;
    logic [N-1:0]     gnt_o;
    logic [N-1:0]     done_o;
    logic             busy_o;
    logic             load_o;
    logic             en_o;
    logic [W-1:0]     data_o;
    logic [W-1:0]     cnt_i;
`ifdef COUNTER8_SCHED_ABORT_EN
    logic             abort_i;
    logic             aborted_o;
`endif

    counter8_sched #(.NUM_REQ(N), .CNT_W(W)) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .req_i   (req_i),
        .delay_i (delay_i),
        .gnt_o   (gnt_o),
        .done_o  (done_o),
        .busy_o  (busy_o),
        .load_o  (load_o),
        .en_o    (en_o),
        .data_o  (data_o),
        .cnt_i   (cnt_i)
`ifdef COUNTER8_SCHED_ABORT_EN
        ,
        .abort_i   (abort_i),
        .aborted_o (aborted_o)
`endif
    );

    always #5 clk = ~clk;

    // Shared counter8 beside the scheduler: load wins, else count up with wrap.
    logic [W-1:0] cnt_q = '0;
    assign cnt_i = cnt_q;
    always @(posedge clk) begin
        if (load_o)    cnt_q <= data_o;
        else if (en_o) cnt_q <= cnt_q + 1'b1;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int idx;
        int delay;
        int done_cyc;
        bit aborted;
    } job_t;

    job_t sb [$];
    int   vectors = 0;
    int   miscompares = 0;
    int   ptr_m = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops one expected job per done_o pulse and checks the whole job footprint.
    initial begin
        int en_cnt, load_cnt, gnt_cnt;
        job_t e;
        en_cnt = 0; load_cnt = 0; gnt_cnt = 0;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                en_cnt = 0; load_cnt = 0; gnt_cnt = 0;
            end else begin
                check("gnt_onehot0", 32'($onehot0(gnt_o)), 1);
                if (en_o)      en_cnt++;
                if (load_o)    load_cnt++;
                if (gnt_o != 0) gnt_cnt++;
                if (sb.size() > 0)
                    check("en_at_target", 32'(en_o && (int'(cnt_i) == sb[0].delay)), 0);
                if (done_o != 0) begin
                    if (sb.size() == 0) begin
                        check("unexpected_done", 32'(done_o), 0);
                    end else begin
                        e = sb.pop_front();
                        check("done_value", 32'(done_o), 32'(1 << e.idx));
                        check("done_cycle", 32'(cyc), 32'(e.done_cyc));
                        check("en_cycles", 32'(en_cnt), 32'(e.delay));
                        check("load_cycles", 32'(load_cnt), 1);
                        check("gnt_cycles", 32'(gnt_cnt), 32'(e.delay + 2));
                        check("gnt_clear_at_done", 32'(gnt_o), 0);
`ifdef COUNTER8_SCHED_ABORT_EN
                        check("aborted_at_done", 32'(aborted_o), 32'(e.aborted));
`endif
                    end
                    en_cnt = 0; load_cnt = 0; gnt_cnt = 0;
                end
`ifdef COUNTER8_SCHED_ABORT_EN
                else begin
                    check("aborted_idle", 32'(aborted_o), 0);
                end
`endif
            end
        end
    end

    // Model: from a static request mask, jobs run in round-robin order; each job
    // sampled at cycle s completes at s+3+D and the next sample is one cycle later.
    task automatic run_scenario(input logic [N-1:0] mask, input int dl [N]);
        int s, p, last;
        int beg [N];
        int drop [N];
        logic [N-1:0] pend;
        logic exp_busy;
        job_t j;
        for (int k = 0; k < N; k++) begin
            delay_i[k*W +: W] = W'(dl[k]);
            beg[k]  = -1;
            drop[k] = -1;
        end
        req_i = mask;
        s = cyc; p = ptr_m; pend = mask; last = s;
        while (pend != 0) begin
            bit found = 0;
            for (int i = 0; i < N; i++) begin
                int k = (p + i) % N;
                if (!found && pend[k]) begin
                    found      = 1;
                    j.idx      = k;
                    j.delay    = dl[k];
                    j.done_cyc = s + 3 + dl[k];
                    j.aborted  = 0;
                    sb.push_back(j);
                    beg[k]  = s;
                    drop[k] = j.done_cyc;
                    pend[k] = 1'b0;
                    p    = (k + 1) % N;
                    last = j.done_cyc;
                    s    = j.done_cyc + 1;
                end
            end
        end
        ptr_m = p;
        while (cyc < last + 1) begin
            tick();
            exp_busy = 1'b0;
            for (int k = 0; k < N; k++) begin
                if (beg[k] >= 0 && cyc > beg[k] && cyc <= drop[k]) exp_busy = 1'b1;
                if (cyc == drop[k]) begin
                    req_i[k] = 1'b0;
                end else if (beg[k] >= 0 && cyc > beg[k] && cyc < drop[k]) begin
                    // Granted requester's inputs are ignored until its job ends.
                    if ($urandom_range(3) == 0) delay_i[k*W +: W] = W'($urandom);
                    req_i[k] = 1'($urandom_range(1));
                end
            end
            check("busy", 32'(busy_o), 32'(exp_busy));
        end
        tick();
        check("scoreboard_drained", 32'(sb.size()), 0);
        check("busy_after_drain", 32'(busy_o), 0);
    endtask

    initial begin
        int dl [N];
        int s;
        rst_i = 1'b1;
        req_i = '0;
        delay_i = '0;
`ifdef COUNTER8_SCHED_ABORT_EN
        abort_i = 1'b0;
`endif
        repeat (3) tick();
        check("rst_gnt", 32'(gnt_o), 0);
        check("rst_done", 32'(done_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_load", 32'(load_o), 0);
        check("rst_en", 32'(en_o), 0);
        check("rst_data", 32'(data_o), 0);
        rst_i = 1'b0;
        tick();

        // Single requester, D=5.
        dl = '{5, 0, 0, 0};
        run_scenario(4'b0001, dl);
        // Zero delay on requester 1.
        dl = '{0, 0, 0, 0};
        run_scenario(4'b0010, dl);
        // Max delay on requester 2.
        dl = '{0, 0, 255, 0};
        run_scenario(4'b0100, dl);

        // Reset in the middle of a job at cnt_i=3.
        req_i = 4'b0001;
        delay_i[0 +: W] = 8'd10;
        repeat (5) tick();
        check("cnt_before_reset", 32'(cnt_i), 3);
        check("en_before_reset", 32'(en_o), 1);
        rst_i = 1'b1;
        #1;
        check("en_in_reset_cycle", 32'(en_o), 0);
        check("load_in_reset_cycle", 32'(load_o), 0);
        tick();
        sb.delete();
        ptr_m = 0;
        check("mid_rst_gnt", 32'(gnt_o), 0);
        check("mid_rst_done", 32'(done_o), 0);
        check("mid_rst_busy", 32'(busy_o), 0);
        rst_i = 1'b0;
        req_i = '0;
        tick();
        check("post_rst_done", 32'(done_o), 0);

        // All four requesting with D=2: order 0,1,2,3 after reset.
        dl = '{2, 2, 2, 2};
        run_scenario(4'b1111, dl);

`ifdef COUNTER8_SCHED_ABORT_EN
        // Abort at cnt_i=4 on a D=10 job: looks like a completed D=4 job plus aborted_o.
        begin
            job_t j;
            req_i = 4'b0001;
            delay_i[0 +: W] = 8'd10;
            s = cyc;
            j.idx = 0; j.delay = 4; j.done_cyc = s + 7; j.aborted = 1;
            sb.push_back(j);
            ptr_m = (ptr_m == 0) ? 1 : ptr_m;
            repeat (6) tick();
            check("abort_cnt", 32'(cnt_i), 4);
            abort_i = 1'b1;
            #1;
            check("abort_en_low", 32'(en_o), 0);
            tick();
            abort_i = 1'b0;
            req_i = '0;
            repeat (2) tick();
            check("abort_drained", 32'(sb.size()), 0);
            ptr_m = 1;
            // Pointer advanced past 0: requester 1 wins over 0.
            dl = '{1, 1, 0, 0};
            run_scenario(4'b0011, dl);
        end
`endif

        // Randomized request masks and delays.
        for (int r = 0; r < 25; r++) begin
            for (int k = 0; k < N; k++)
                dl[k] = ($urandom_range(9) == 0) ? int'($urandom_range(200, 255))
                                                 : int'($urandom_range(0, 12));
            run_scenario(4'($urandom_range(1, 15)), dl);
            repeat ($urandom_range(0, 3)) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
